// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtraction controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// One-bit full subtractor: d = x - y - bi, bo set when that goes below zero.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one shared fs_cell walks the operands LSB-first,
// with a start/busy/done handshake towards the requester.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr, diff_shift;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_bo;
  logic             last_bit;

  fs_cell u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign last_bit = (cnt == LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Diff register contents after the current RUN step; also feeds the result
  // registers on the final step so they are valid while done is high.
  always_comb begin
    diff_shift             = diff_sr >> 1;
    diff_shift[WIDTH-1]    = cell_d;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      diff_sr    <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= diff_shift;
          borrow  <= cell_bo;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            diff       <= diff_shift;
            borrow_out <= cell_bo;
            zero       <= (diff_shift == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed scoreboard bench for serial_sub_ctrl (WIDTH=8 main instance, WIDTH=1 corner instance).
module tb_serial_sub_ctrl;

  typedef struct {
    logic [7:0] diff;
    logic       bo;
    logic       z;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       bin = 1'b0;
  logic       busy, done, borrow_out, zero;
  logic [7:0] diff;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, borrow_out1, zero1;
  logic [0:0] diff1;

  exp_t sb[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .zero(zero)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow_out1), .zero(zero1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
    exp_t e;
    logic [8:0] full;
    full   = {1'b0, ia} - {1'b0, ib} - {8'd0, ibin};
    e.diff = full[7:0];
    e.bo   = full[8];
    e.z    = (full[7:0] == 8'd0);
    e.acc  = 0;
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input bit track);
    exp_t e;
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    e     = model(ia, ib, ibin);
    e.acc = cyc + 1;
    if (track) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    bin   = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, {31'd0, done}, 32'd1);
    if (done === 1'b1) begin
      check({tag, "_sb"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_diff"}, {24'd0, diff}, {24'd0, e.diff});
        check({tag, "_bo"}, {31'd0, borrow_out}, {31'd0, e.bo});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
        check({tag, "_lat"}, 32'(cyc - e.acc), 32'd8);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
    end
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int   cnt_done;
    int   acc1;
    int   n;
    exp_t e;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bo", {31'd0, borrow_out}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst1_diff", {31'd0, diff1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic vectors
    issue(8'h5A, 8'h21, 1'b0, 1'b1);
    wait_done("sub_5a_21");
    issue(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done("sub_10_20");
    issue(8'h00, 8'h00, 1'b1, 1'b1);
    wait_done("sub_00_00_b");
    issue(8'h37, 8'h36, 1'b1, 1'b1);
    wait_done("sub_37_36_b");

    // start during RUN is ignored
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("ign_busy", {31'd0, busy}, 32'd1);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    cnt_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt_done++;
    end
    check("ign_extra_done", 32'(cnt_done), 32'd0);

    // asynchronous abort mid-RUN
    issue(8'hAA, 8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_bo", {31'd0, borrow_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) cnt_done++;
    end
    check("abort_quiet", 32'(cnt_done), 32'd0);
    issue(8'h09, 8'h03, 1'b0, 1'b1);
    wait_done("after_abort");

    // start held high: back-to-back requests every WIDTH+2 cycles
    a     = 8'h05;
    b     = 8'h02;
    bin   = 1'b0;
    start = 1'b1;
    n     = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e     = model(8'h05, 8'h02, 1'b0);
      e.acc = n + 10 * k;
      sb.push_back(e);
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        while (done !== 1'b1 && cyc < n + 40) @(negedge clk);
        start = 1'b0;
      end
      wait_done("held");
    end
    repeat (4) @(negedge clk);
    check("held_idle", {31'd0, busy}, 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    // WIDTH=1 instance
    a1     = 1'b0;
    b1     = 1'b1;
    bin1   = 1'b0;
    start1 = 1'b1;
    acc1   = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("w1_seen", {31'd0, done1}, 32'd1);
    check("w1_lat", 32'(cyc - acc1), 32'd1);
    check("w1_diff", {31'd0, diff1}, 32'd1);
    check("w1_bo", {31'd0, borrow_out1}, 32'd1);
    check("w1_zero", {31'd0, zero1}, 32'd0);
    @(negedge clk);
    check("w1_pulse", {31'd0, done1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
